// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock supervisor with staged per-domain reset release
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int RELEASE_GAP   = 8,
    parameter int NUM_DOMAINS   = 3,
    parameter int MAX_RETRIES   = 4
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   locked,
    input  logic                   relock_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] dom_rst,
    output logic                   ready,
    output logic                   fault,
    output logic [7:0]             retry_cnt,
    output logic [7:0]             loss_cnt
);

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAULT
    } state_t;

    localparam int REL_LEN = (NUM_DOMAINS - 1) * RELEASE_GAP;
    localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B   = (STABLE_CYCLES > REL_LEN) ? STABLE_CYCLES : REL_LEN;
    localparam int MAX_P   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW      = $clog2(MAX_P + 1);

    localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] REL_LAST     = TW'((REL_LEN > 0) ? REL_LEN - 1 : 0);

    // A single domain is released in the same cycle RUN is entered, so RELEASE is skipped.
    localparam state_t REL_TARGET = (NUM_DOMAINS == 1) ? S_RUN : S_RELEASE;

    state_t                 state, state_n;
    logic [TW-1:0]          tmr, tmr_n;
    logic [7:0]             retry_n, loss_n, retry_inc, loss_inc;
    logic                   lock_meta, locked_s;
    logic                   pll_rst_n, ready_n, fault_n;
    logic [NUM_DOMAINS-1:0] dom_rst_n;

    assign retry_inc = (retry_cnt == 8'hFF) ? 8'hFF : retry_cnt + 8'd1;
    assign loss_inc  = (loss_cnt == 8'hFF) ? 8'hFF : loss_cnt + 8'd1;

    always_comb begin
        state_n = state;
        tmr_n   = tmr + TW'(1);
        retry_n = retry_cnt;
        loss_n  = loss_cnt;

        if (relock_req) begin
            state_n = S_RESET;
            tmr_n   = '0;
            retry_n = '0;
        end else begin
            case (state)
                S_RESET: begin
                    if (tmr == RST_LAST) begin
                        state_n = S_WAIT_LOCK;
                        tmr_n   = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    // The cycle that sees lock here counts as the first stable cycle.
                    if (locked_s) begin
                        if (STABLE_CYCLES == 1) begin
                            state_n = REL_TARGET;
                            tmr_n   = '0;
                        end else begin
                            state_n = S_STABLE;
                            tmr_n   = TW'(1);
                        end
                    end else if (tmr == TIMEOUT_LAST) begin
                        retry_n = retry_inc;
                        tmr_n   = '0;
                        state_n = (int'(retry_cnt) + 1 >= MAX_RETRIES) ? S_FAULT : S_RESET;
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state_n = S_WAIT_LOCK;
                        tmr_n   = '0;
                    end else if (tmr == STABLE_LAST) begin
                        state_n = REL_TARGET;
                        tmr_n   = '0;
                    end
                end
                S_RELEASE: begin
                    if (!locked_s) begin
                        state_n = S_RESET;
                        tmr_n   = '0;
                        loss_n  = loss_inc;
                    end else if (tmr == REL_LAST) begin
                        state_n = S_RUN;
                        tmr_n   = '0;
                    end
                end
                S_RUN: begin
                    tmr_n = tmr;
                    if (!locked_s) begin
                        state_n = S_RESET;
                        tmr_n   = '0;
                        loss_n  = loss_inc;
                    end
                end
                S_FAULT: begin
                    tmr_n = tmr;
                end
                default: begin
                    state_n = S_RESET;
                    tmr_n   = '0;
                end
            endcase
        end

        if (state_n == S_RUN && state != S_RUN) begin
            retry_n = '0;
        end

        // Outputs are decoded from the next state so they register alongside it.
        pll_rst_n = (state_n == S_RESET) || (state_n == S_FAULT);
        ready_n   = (state_n == S_RUN);
        fault_n   = (state_n == S_FAULT);
        dom_rst_n = '1;
        if (state_n == S_RUN) begin
            dom_rst_n = '0;
        end else if (state_n == S_RELEASE) begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                dom_rst_n[i] = (i * RELEASE_GAP > int'(tmr_n));
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= S_RESET;
            tmr       <= '0;
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
            pll_rst   <= 1'b1;
            dom_rst   <= '1;
            ready     <= 1'b0;
            fault     <= 1'b0;
            retry_cnt <= '0;
            loss_cnt  <= '0;
        end else begin
            state     <= state_n;
            tmr       <= tmr_n;
            lock_meta <= locked;
            locked_s  <= lock_meta;
            pll_rst   <= pll_rst_n;
            dom_rst   <= dom_rst_n;
            ready     <= ready_n;
            fault     <= fault_n;
            retry_cnt <= retry_n;
            loss_cnt  <= loss_n;
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - scoreboard bench for pll_lock_sequencer
module tb_pll_lock_sequencer;

    logic       refclk = 1'b0;
    logic       rst;
    logic       locked;
    logic       relock_req;
    logic       pll_rst;
    logic [2:0] dom_rst;
    logic       ready;
    logic       fault;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          at;
        string       tag;
        logic [21:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];

    pll_lock_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (32),
        .STABLE_CYCLES(8),
        .RELEASE_GAP  (2),
        .NUM_DOMAINS  (3),
        .MAX_RETRIES  (2)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .locked    (locked),
        .relock_req(relock_req),
        .pll_rst   (pll_rst),
        .dom_rst   (dom_rst),
        .ready     (ready),
        .fault     (fault),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt)
    );

    always #5 refclk = ~refclk;

    always @(posedge refclk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Snapshot layout: {pll_rst, dom_rst[2:0], ready, fault, retry_cnt, loss_cnt}
    task automatic expect_at(input int at, input string tag, input logic pll,
                             input logic [2:0] dom, input logic rdy, input logic flt,
                             input logic [7:0] rt, input logic [7:0] ls);
        sb_entry_t e;
        e.at  = at;
        e.tag = tag;
        e.exp = {pll, dom, rdy, flt, rt, ls};
        sb.push_back(e);
    endtask

    task automatic expect_release(input int l, input logic [7:0] ls);
        expect_at(l + 9,  "pre_release", 1'b0, 3'b111, 1'b0, 1'b0, 8'd0, ls);
        expect_at(l + 10, "dom0_clear",  1'b0, 3'b110, 1'b0, 1'b0, 8'd0, ls);
        expect_at(l + 11, "dom1_held",   1'b0, 3'b110, 1'b0, 1'b0, 8'd0, ls);
        expect_at(l + 12, "dom1_clear",  1'b0, 3'b100, 1'b0, 1'b0, 8'd0, ls);
        expect_at(l + 13, "dom2_held",   1'b0, 3'b100, 1'b0, 1'b0, 8'd0, ls);
        expect_at(l + 14, "ready",       1'b0, 3'b000, 1'b1, 1'b0, 8'd0, ls);
    endtask

    task automatic goto(input int k);
        while (cyc < k) begin
            @(posedge refclk);
            #1;
        end
    endtask

    always @(negedge refclk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                check_value(sb[i].tag,
                            {10'd0, pll_rst, dom_rst, ready, fault, retry_cnt, loss_cnt},
                            {10'd0, sb[i].exp});
                sb.delete(i);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        locked     = 1'b0;
        relock_req = 1'b0;

        // Nominal bring-up
        expect_at(3, "reset_state", 1'b1, 3'b111, 1'b0, 1'b0, 8'd0, 8'd0);
        goto(3);
        rst = 1'b0;
        expect_at(6, "rst_hold", 1'b1, 3'b111, 1'b0, 1'b0, 8'd0, 8'd0);
        expect_at(7, "pll_fall", 1'b0, 3'b111, 1'b0, 1'b0, 8'd0, 8'd0);
        goto(12);
        locked = 1'b1;
        expect_release(12, 8'd0);

        // Loss in RUN
        goto(30);
        locked = 1'b0;
        expect_at(32, "run_hold",      1'b0, 3'b000, 1'b1, 1'b0, 8'd0, 8'd0);
        expect_at(33, "loss_run",      1'b1, 3'b111, 1'b0, 1'b0, 8'd0, 8'd1);
        expect_at(36, "loss_rst_hold", 1'b1, 3'b111, 1'b0, 1'b0, 8'd0, 8'd1);
        expect_at(37, "loss_wait",     1'b0, 3'b111, 1'b0, 1'b0, 8'd0, 8'd1);
        goto(37);
        locked = 1'b1;
        expect_release(37, 8'd1);

        // relock_req coincident with lock loss seen in RUN
        goto(55);
        locked = 1'b0;
        goto(57);
        relock_req = 1'b1;
        expect_at(58, "relock_loss", 1'b1, 3'b111, 1'b0, 1'b0, 8'd0, 8'd1);
        expect_at(61, "relock_hold", 1'b1, 3'b111, 1'b0, 1'b0, 8'd0, 8'd1);
        expect_at(62, "relock_wait", 1'b0, 3'b111, 1'b0, 1'b0, 8'd0, 8'd1);
        goto(58);
        relock_req = 1'b0;

        // Loss mid-RELEASE
        goto(62);
        locked = 1'b1;
        expect_at(72, "rel_dom0", 1'b0, 3'b110, 1'b0, 1'b0, 8'd0, 8'd1);
        goto(72);
        locked = 1'b0;
        expect_at(74, "rel_partial",  1'b0, 3'b100, 1'b0, 1'b0, 8'd0, 8'd1);
        expect_at(75, "loss_release", 1'b1, 3'b111, 1'b0, 1'b0, 8'd0, 8'd2);
        expect_at(76, "no_ready",     1'b1, 3'b111, 1'b0, 1'b0, 8'd0, 8'd2);

        // Timeout retry then fault, recovered by relock_req
        expect_at(110, "wait_pre_to",    1'b0, 3'b111, 1'b0, 1'b0, 8'd0, 8'd2);
        expect_at(111, "timeout1",       1'b1, 3'b111, 1'b0, 1'b0, 8'd1, 8'd2);
        expect_at(114, "retry_rst_hold", 1'b1, 3'b111, 1'b0, 1'b0, 8'd1, 8'd2);
        expect_at(115, "retry_wait",     1'b0, 3'b111, 1'b0, 1'b0, 8'd1, 8'd2);
        expect_at(146, "wait_pre_to2",   1'b0, 3'b111, 1'b0, 1'b0, 8'd1, 8'd2);
        expect_at(147, "fault",          1'b1, 3'b111, 1'b0, 1'b1, 8'd2, 8'd2);
        expect_at(160, "fault_hold",     1'b1, 3'b111, 1'b0, 1'b1, 8'd2, 8'd2);
        goto(160);
        relock_req = 1'b1;
        expect_at(161, "relock_clear", 1'b1, 3'b111, 1'b0, 1'b0, 8'd0, 8'd2);
        expect_at(164, "relock_rst",   1'b1, 3'b111, 1'b0, 1'b0, 8'd0, 8'd2);
        expect_at(165, "relock_pll",   1'b0, 3'b111, 1'b0, 1'b0, 8'd0, 8'd2);
        goto(161);
        relock_req = 1'b0;

        // One-cycle lock glitch during STABLE
        goto(165);
        locked = 1'b1;
        expect_at(173, "glitch_back",  1'b0, 3'b111, 1'b0, 1'b0, 8'd0, 8'd2);
        expect_at(175, "no_early_rel", 1'b0, 3'b111, 1'b0, 1'b0, 8'd0, 8'd2);
        goto(170);
        locked = 1'b0;
        goto(171);
        locked = 1'b1;
        expect_release(171, 8'd2);

        // rst asserted during WAIT_LOCK
        goto(190);
        locked = 1'b0;
        expect_at(193, "loss_run2",       1'b1, 3'b111, 1'b0, 1'b0, 8'd0, 8'd3);
        expect_at(197, "wait_before_rst", 1'b0, 3'b111, 1'b0, 1'b0, 8'd0, 8'd3);
        goto(198);
        rst = 1'b1;
        expect_at(199, "rst_mid",      1'b1, 3'b111, 1'b0, 1'b0, 8'd0, 8'd0);
        expect_at(202, "rst_mid_hold", 1'b1, 3'b111, 1'b0, 1'b0, 8'd0, 8'd0);
        expect_at(203, "rst_mid_wait", 1'b0, 3'b111, 1'b0, 1'b0, 8'd0, 8'd0);
        goto(199);
        rst = 1'b0;

        goto(210);
        check_value("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
